// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StAck
  } mpa_state_e;

  typedef enum logic {
    OwnI,
    OwnD
  } mpa_owner_e;

  // Width of a down-counter that must hold the value lat.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side requests/responses plus the memory-side bus of the shared port arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              hlt;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_re;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              stall_if;
  logic              stall_d;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output hlt, if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, stall_if, stall_d,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  hlt, if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, stall_if, stall_d,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mpa_lat_counter.sv
// Access-length counter: loads LAT on accept, counts down, flags the last access cycle.
module mpa_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic last
);
  localparam int unsigned CntW = cnt_width(LAT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CntW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one single-ported memory, data first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LAT    = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  mpa_state_e        state_q, state_d;
  mpa_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              we_q;

  logic in_ack, busy, can_accept;
  logic d_pend, i_pend, accept_d, accept_i, accept;
  logic cnt_last, capture;
  logic if_ack, d_ack;

  assign in_ack     = (state_q == StAck);
  assign busy       = (state_q == StBusyI) || (state_q == StBusyD);
  assign can_accept = (state_q == StIdle) || in_ack;

  // The requester being acked this cycle still holds its req; it must not be re-accepted.
  assign d_pend   = (bus.d_re | bus.d_we) & ~(in_ack & (owner_q == OwnD));
  assign i_pend   = bus.if_req & ~bus.hlt & ~(in_ack & (owner_q == OwnI));
  assign accept_d = can_accept & d_pend;
  assign accept_i = can_accept & ~d_pend & i_pend;
  assign accept   = accept_d | accept_i;
  assign capture  = busy & cnt_last & ~we_q;

  mpa_lat_counter #(
    .LAT (LAT)
  ) u_lat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle, StAck: begin
        if (accept_d) begin
          state_d = StBusyD;
          owner_d = OwnD;
        end else if (accept_i) begin
          state_d = StBusyI;
          owner_d = OwnI;
        end else begin
          state_d = StIdle;
        end
      end
      StBusyI, StBusyD: begin
        if (cnt_last) state_d = StAck;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= OwnI;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (accept_d) begin
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        we_q        <= bus.d_we;
      end else if (accept_i) begin
        mem_addr_q <= bus.if_addr;
        we_q       <= 1'b0;
      end
      if (capture) begin
        if (owner_q == OwnD) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign if_ack = in_ack & (owner_q == OwnI);
  assign d_ack  = in_ack & (owner_q == OwnD);

  assign bus.if_ack    = if_ack;
  assign bus.d_ack     = d_ack;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ack;
  assign bus.stall_d   = (bus.d_re | bus.d_we) & ~d_ack;
  // Enable stays up through an ACK that hands the port straight to the next requester.
  assign bus.mem_en    = busy | (in_ack & accept);
  assign bus.mem_we    = busy & we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 has LAT=2, instances 1 and 2 have LAT=1 and LAT=4.
module tb_mem_port_arbiter;
  localparam int NI = 3;
  localparam int L0 = 2;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        hlt     [NI];
  logic        if_req  [NI];
  logic [15:0] if_addr [NI];
  logic        d_re    [NI];
  logic        d_we    [NI];
  logic [15:0] d_addr  [NI];
  logic [15:0] d_wdata [NI];

  wire  [15:0] if_rdata  [NI];
  wire         if_ack    [NI];
  wire  [15:0] d_rdata   [NI];
  wire         d_ack     [NI];
  wire         stall_if  [NI];
  wire         stall_d   [NI];
  wire         mem_en    [NI];
  wire         mem_we    [NI];
  wire  [15:0] mem_addr  [NI];
  wire  [15:0] mem_wdata [NI];

  int total = 0;
  int bad   = 0;

  // Memory model: one special word, everything else is a fixed scramble of the address.
  function automatic logic [15:0] rd_fn(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA123 : (a ^ 16'h3C5A);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    assign bus.hlt       = hlt[g];
    assign bus.if_req    = if_req[g];
    assign bus.if_addr   = if_addr[g];
    assign bus.d_re      = d_re[g];
    assign bus.d_we      = d_we[g];
    assign bus.d_addr    = d_addr[g];
    assign bus.d_wdata   = d_wdata[g];
    assign bus.mem_rdata = bus.mem_en ? rd_fn(bus.mem_addr) : 16'hDEAD;

    assign if_rdata[g]  = bus.if_rdata;
    assign if_ack[g]    = bus.if_ack;
    assign d_rdata[g]   = bus.d_rdata;
    assign d_ack[g]     = bus.d_ack;
    assign stall_if[g]  = bus.stall_if;
    assign stall_d[g]   = bus.stall_d;
    assign mem_en[g]    = bus.mem_en;
    assign mem_we[g]    = bus.mem_we;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_wdata[g] = bus.mem_wdata;

    mem_port_arbiter #(
      .ADDR_W (16),
      .DATA_W (16),
      .LAT    ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard for instance 0: one entry per expected ack, in completion order.
  typedef struct {
    logic        is_d;
    logic [15:0] exp_if;
    logic [15:0] exp_d;
  } sb_t;
  sb_t         sb [$];
  logic [15:0] model_if;
  logic [15:0] model_d;

  task automatic push_exp(input logic is_d, input logic we, input logic [15:0] data);
    sb_t e;
    if (!we) begin
      if (is_d) model_d = data;
      else      model_if = data;
    end
    e.is_d   = is_d;
    e.exp_if = model_if;
    e.exp_d  = model_d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst_n && (if_ack[0] || d_ack[0])) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", {30'd0, if_ack[0], d_ack[0]}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_ack_port", {30'd0, if_ack[0], d_ack[0]}, e.is_d ? 32'd1 : 32'd2);
        check("sb_if_rdata", {16'd0, if_rdata[0]}, {16'd0, e.exp_if});
        check("sb_d_rdata", {16'd0, d_rdata[0]}, {16'd0, e.exp_d});
      end
    end
  end

  // Waits for the given port's ack on instance k, then drops that port's request.
  task automatic wait_ack(input int k, input logic use_d, output int n_ack);
    n_ack = 0;
    for (int n = 1; n <= 20 && n_ack == 0; n++) begin
      @(negedge clk);
      if (use_d ? d_ack[k] : if_ack[k]) begin
        n_ack = n;
        if (use_d) begin
          d_re[k] = 1'b0;
          d_we[k] = 1'b0;
        end else begin
          if_req[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_req(input string nm, input logic use_d, input logic re, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_data, input int exp_wcnt);
    int   ack_n = 0;
    int   wcnt  = 0;
    int   werr  = 0;
    int   serr  = 0;
    logic is_ack;
    push_exp(use_d, we, exp_data);
    @(posedge clk); #1;
    if (use_d) begin
      d_re[0] = re; d_we[0] = we; d_addr[0] = addr; d_wdata[0] = wdata;
    end else begin
      if_req[0] = 1'b1; if_addr[0] = addr;
    end
    for (int n = 1; n <= 20 && ack_n == 0; n++) begin
      @(negedge clk);
      is_ack = use_d ? d_ack[0] : if_ack[0];
      if (mem_we[0]) begin
        wcnt++;
        if (mem_addr[0] !== addr || mem_wdata[0] !== wdata) werr++;
      end
      if ((use_d ? stall_d[0] : stall_if[0]) !== ~is_ack) serr++;
      if (n == 2) begin
        d_addr[0] = ~addr; d_wdata[0] = ~wdata; if_addr[0] = ~addr;
      end
      if (is_ack) ack_n = n;
    end
    check({nm, "_latency"}, ack_n, L0 + 2);
    check({nm, "_stall"}, serr, 0);
    check({nm, "_wr_cycles"}, wcnt, exp_wcnt);
    check({nm, "_wr_values"}, werr, 0);
    @(posedge clk); #1;
    if_req[0] = 1'b0; d_re[0] = 1'b0; d_we[0] = 1'b0;
  endtask

  task automatic hold_test(input int k, input int lat, input logic use_d);
    int win    = 3 * (lat + 2);
    int acks   = 0;
    int first  = 0;
    int en_cnt = 0;
    @(posedge clk); #1;
    if (use_d) begin d_re[k] = 1'b1; d_addr[k] = 16'h0040; end
    else       begin if_req[k] = 1'b1; if_addr[k] = 16'h0040; end
    for (int n = 1; n <= win + lat + 3; n++) begin
      @(negedge clk);
      if (use_d ? d_ack[k] : if_ack[k]) begin
        acks++;
        if (first == 0) first = n;
      end
      if (mem_en[k]) en_cnt++;
      if (n == win) begin
        d_re[k] = 1'b0; if_req[k] = 1'b0;
      end
    end
    check($sformatf("hold%0d_ack_count", k), acks, 3);
    check($sformatf("hold%0d_first_ack", k), first, lat + 2);
    check($sformatf("hold%0d_en_cycles", k), en_cnt, 3 * lat);
    check($sformatf("hold%0d_rdata", k), use_d ? {16'd0, d_rdata[k]} : {16'd0, if_rdata[k]},
          32'h3C1A);
  endtask

  typedef struct {
    logic        use_d;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    int          exp_wcnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int da, ia, en, acks, st;
    for (int k = 0; k < NI; k++) begin
      hlt[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
      d_re[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    model_if = '0;
    model_d  = '0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA123, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h3D5A, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0200, 16'h5A5A, 16'h0000, 2};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h3C5E, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0210, 16'h1234, 16'h0000, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h3CA5, 0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset%0d_en_we", k), {30'd0, mem_en[k], mem_we[k]}, 32'd0);
      check($sformatf("reset%0d_acks", k), {30'd0, if_ack[k], d_ack[k]}, 32'd0);
    end
    check("reset_mem_addr", {16'd0, mem_addr[0]}, 32'd0);
    check("reset_mem_wdata", {16'd0, mem_wdata[0]}, 32'd0);
    check("reset_rdata", {if_rdata[0], d_rdata[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].use_d, vecs[i].re, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_wcnt);
    end

    // Both requesters at once: data first, IF handed the port in the ACK cycle.
    push_exp(1'b1, 1'b0, 16'h3D5A);
    push_exp(1'b0, 1'b0, 16'h3C5E);
    @(posedge clk); #1;
    if_req[0] = 1'b1; if_addr[0] = 16'h0004; d_re[0] = 1'b1; d_addr[0] = 16'h0100;
    da = 0; ia = 0; en = 0;
    for (int n = 1; n <= 20 && ia == 0; n++) begin
      @(negedge clk);
      if (mem_en[0]) en++;
      if (d_ack[0]) begin da = n; d_re[0] = 1'b0; end
      if (if_ack[0]) begin ia = n; if_req[0] = 1'b0; end
    end
    check("both_d_ack_cycle", da, 4);
    check("both_if_ack_cycle", ia, 7);
    check("both_mem_en_cycles", en, 5);

    // Halt raised mid-fetch: fetch completes, further fetches refused, data still served.
    push_exp(1'b0, 1'b0, 16'hA123);
    @(posedge clk); #1;
    if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    ia = 0;
    for (int n = 1; n <= 20 && ia == 0; n++) begin
      @(negedge clk);
      if (n == 2) hlt[0] = 1'b1;
      if (if_ack[0]) ia = n;
    end
    check("hlt_inflight_latency", ia, 4);
    en = 0; acks = 0; st = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_en[0]) en++;
      if (if_ack[0]) acks++;
      if (!stall_if[0]) st++;
    end
    check("hlt_mem_en_cycles", en, 0);
    check("hlt_if_acks", acks, 0);
    check("hlt_stall_low_cycles", st, 0);
    push_exp(1'b1, 1'b0, 16'h3D0A);
    @(posedge clk); #1;
    d_re[0] = 1'b1; d_addr[0] = 16'h0150;
    wait_ack(0, 1'b1, da);
    check("hlt_data_latency", da, 4);
    push_exp(1'b0, 1'b0, 16'h3C6A);
    @(posedge clk); #1;
    hlt[0] = 1'b0; if_addr[0] = 16'h0030;
    wait_ack(0, 1'b0, ia);
    check("unhalt_if_latency", ia, 4);

    // Asynchronous reset in the middle of a data access discards it.
    push_exp(1'b1, 1'b0, 16'h3D5A);
    @(posedge clk); #1;
    d_re[0] = 1'b1; d_addr[0] = 16'h0100;
    repeat (2) @(negedge clk);
    check("rst_pre_mem_en", {31'd0, mem_en[0]}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    model_if = '0;
    model_d  = '0;
    #1;
    check("rst_mem_en", {31'd0, mem_en[0]}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack[0]}, 32'd0);
    check("rst_d_rdata", {16'd0, d_rdata[0]}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr[0]}, 32'd0);
    d_re[0] = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_req("post_rst", 1'b1, 1'b1, 1'b0, 16'h0120, 16'h0000, 16'h3D7A, 0);

    // Requests held through ACK on the LAT=1 and LAT=4 instances.
    hold_test(1, 1, 1'b1);
    hold_test(2, 4, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
